shiftrows_stream: RTL and testbench
===================================

// Module: shiftrows_stream
// PURPOSE
// - Streaming AES ShiftRows / InvShiftRows stage for the byte-serial datapath, sitting between SubBytes and MixColumns.
// - Accepts 16-byte states as LANES bytes per beat in column-major order (s00,s10,s20,s30,s01,...).
// - Emits the permuted state in the same order.
// - Double-buffered (ping-pong), so one block fills while the previous one drains.
// - Per-block mode select: forward or inverse, for the shared enc/dec datapath.
// PARAMETERS
// - LANES  1  bytes per beat; legal values 1,2,4,8,16 (must divide 16). BEATS = 16/LANES is a localparam.
// - INV_EN 1  0: in_inv is ignored and forward ShiftRows is always applied.
// PORTS
// - clock     in   1         single clock; all state updates on the rising edge
// - resetn    in   1         asynchronous, active-low reset
// - in_valid  in   1         in_data and in_inv are valid this cycle
// - in_ready  out  1         stage can accept a beat
// - in_data   in   8*LANES   lane i = bits [8i+7:8i]; lane 0 is the earliest byte in stream order
// - in_inv    in   1         1 = InvShiftRows; sampled only on the first beat of a block
// - out_valid out  1         out_data holds a valid beat
// - out_ready in   1         downstream accepts the beat
// - out_data  out  8*LANES   permuted beat, same lane order as in_data
// - out_last  out  1         high on the final beat (BEATS-1) of a block
// BEHAVIOUR
// - Storage: two banks, each 16 bytes + mode bit + full flag.
// - Pointers: wr_ptr and rd_ptr (1 bit each); beat counters wr_cnt and rd_cnt (0..BEATS-1).
// - Reset (async, resetn=0): flags, pointers and counters clear.
//   - Outputs: in_ready=1 (once resetn=1), out_valid=0, out_data=0, out_last=0.
//   - A partially written or partially read block is discarded; nothing resumes after reset.
// - Input side:
//   - in_ready = !full[wr_ptr].
//   - A beat is accepted when in_valid && in_ready. It writes lanes to bytes wr_cnt*LANES+i, and wr_cnt increments.
//   - Beat 0 latches in_inv (forced to 0 if INV_EN=0) into the bank's mode bit.
//   - Beat BEATS-1 sets full[wr_ptr], toggles wr_ptr and wraps wr_cnt to 0.
// - Output side:
//   - out_valid = full[rd_ptr].
//   - out byte k=4c+r is bank[4*((c+r)%4)+r] when forward, bank[4*((c-r+4)%4)+r] when inverse.
//   - out_data is zero when out_valid=0.
//   - A beat transfers on out_valid && out_ready, and rd_cnt increments.
//   - The last beat clears full[rd_ptr], toggles rd_ptr and wraps rd_cnt.
// - Backpressure: while out_valid && !out_ready, out_data and out_last stay stable.
//   - in_data is ignored whenever in_ready=0.
// - Latency: first output beat is valid the cycle after the last input beat of the block is accepted.
// - Throughput: sustained 1 beat/cycle with out_ready held high. At most 2 blocks are buffered.
// - Simultaneous events:
//   - Fill of one bank and drain of the other in the same cycle are both legal.
//   - Clearing full on the final read and setting full on the final write are independent (different banks).
//   - When both banks are full, in_ready=0 until the final read beat of rd_ptr's bank.
//   - in_ready rises the cycle after that beat; there is no combinational ready->ready path.
// - Mode may change between blocks with no bubble. in_inv on non-first beats is don't-care.
// STRUCTURE
// - aes_pkg:
//   - localparam AES_BLOCK_BYTES=16.
//   - Function sr_src_idx(k, inv) returning the source byte index. Shared with the testbench reference model.
// - Sub-module shiftrows_perm: combinational 128-bit permutation with inv input, instanced once on the read bank.
//   - Beat select = out byte slice rd_cnt*LANES.
// - Top level holds the bank registers, counters, pointers and handshake logic.
// TESTING
// - FIPS-197 B round 1, LANES=1, fwd: d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30
//   -> d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5; out_last on the 16th byte.
// - Back-to-back, then 49 de d2 89 45 db 96 f1 7f 39 87 1a 77 02 53 3b
//   -> 49 db 87 3b 45 39 53 89 7f 02 d2 f1 77 de 96 1a; no idle cycle between the two output blocks.
// - Inverse (in_inv=1), input d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5
//   -> d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
// - out_ready=0 for 40 cycles with 3 blocks offered: in_ready drops after 2 blocks.
//   - out_data holds d4 stable throughout.
//   - Releasing out_ready drains both blocks intact, in order; the third block is then accepted.
// - LANES=4: beat d4 27 11 ae packed as 0xae1127d4 -> first out beat 0x305dbfd4; out_last on beat 4.
// - Async reset pulsed after 7 input beats: out_valid=0 immediately.
//   - The next 16 bytes form a fresh block and give the correct permutation; no stale bytes appear.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and the ShiftRows byte-index mapping used by the streaming stage.
package aes_pkg;

  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam int unsigned AES_STATE_W     = 8 * AES_BLOCK_BYTES;

  // Column-major state: output byte k = 4c+r is taken from column (c+r)%4 (fwd) or (c-r)%4 (inv).
  function automatic int unsigned sr_src_idx(input int unsigned k, input logic inv);
    int unsigned c;
    int unsigned r;
    int unsigned col;
    c   = k / 4;
    r   = k % 4;
    col = inv ? (c + 4 - r) % 4 : (c + r) % 4;
    return 4 * col + r;
  endfunction

endpackage

// File: rtl/shiftrows_perm.sv
// Combinational ShiftRows / InvShiftRows permutation of one 16-byte column-major state.
module shiftrows_perm
  import aes_pkg::*;
(
  input  logic [AES_STATE_W-1:0] state_i,
  input  logic                   inv_i,
  output logic [AES_STATE_W-1:0] state_o
);

  always_comb begin
    state_o = '0;
    for (int unsigned k = 0; k < AES_BLOCK_BYTES; k++) begin
      state_o[8*k +: 8] = inv_i ? state_i[8*sr_src_idx(k, 1'b1) +: 8]
                                : state_i[8*sr_src_idx(k, 1'b0) +: 8];
    end
  end

endmodule

// File: rtl/shiftrows_stream.sv
// Streaming ShiftRows stage: ping-pong buffered, LANES bytes per beat, per-block fwd/inv mode.
module shiftrows_stream
  import aes_pkg::*;
#(
  parameter int unsigned LANES  = 1,
  parameter bit          INV_EN = 1'b1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_last
);

  localparam int unsigned BEATS     = AES_BLOCK_BYTES / LANES;
  localparam int unsigned CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BW        = 8 * LANES;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [1:0][AES_STATE_W-1:0] bank_q;
  logic [1:0]                  mode_q;
  logic [1:0]                  full_q, full_d;
  logic                        wr_ptr_q, wr_ptr_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]               rd_cnt_q, rd_cnt_d;

  logic                        wr_fire, rd_fire, wr_last, rd_last;
  logic [AES_STATE_W-1:0]      perm;
  logic [BW-1:0]               beat;

  assign in_ready  = !full_q[wr_ptr_q];
  assign out_valid = full_q[rd_ptr_q];

  always_comb begin
    wr_fire  = in_valid && in_ready;
    rd_fire  = out_valid && out_ready;
    wr_last  = (wr_cnt_q == LAST_BEAT);
    rd_last  = (rd_cnt_q == LAST_BEAT);
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_fire) begin
      wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
      if (wr_last) begin
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = !wr_ptr_q;
      end
    end
    // Write needs a free bank and read needs a full one, so these never hit the same flag.
    if (rd_fire) begin
      rd_cnt_d = rd_last ? '0 : rd_cnt_q + 1'b1;
      if (rd_last) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = !rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Bank contents are only ever read behind a full flag, so they need no reset.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int unsigned b = 0; b < BEATS; b++) begin
        if (wr_cnt_q == CW'(b)) bank_q[wr_ptr_q][b*BW +: BW] <= in_data;
      end
      if (wr_cnt_q == '0) mode_q[wr_ptr_q] <= INV_EN && in_inv;
    end
  end

  shiftrows_perm u_perm (
    .state_i (bank_q[rd_ptr_q]),
    .inv_i   (mode_q[rd_ptr_q]),
    .state_o (perm)
  );

  always_comb begin
    beat = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (rd_cnt_q == CW'(b)) beat = perm[b*BW +: BW];
    end
    out_data = out_valid ? beat : '0;
    out_last = out_valid && rd_last;
  end

endmodule

// File: tb/tb_shiftrows_stream.sv
// Self-checking bench for shiftrows_stream against a row-rotation reference model.
module tb_shiftrows_stream;

  typedef byte unsigned blk_t [16];

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, in_inv, out_valid, out_ready, out_last;
  logic [7:0]  in_data, out_data;
  logic        in_valid4, in_ready4, in_inv4, out_valid4, out_ready4, out_last4;
  logic [31:0] in_data4, out_data4;

  always #5 clock = ~clock;

  shiftrows_stream #(.LANES(1), .INV_EN(1'b1)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  shiftrows_stream #(.LANES(4), .INV_EN(1'b1)) dut4 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_inv(in_inv4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_last(out_last4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  byte unsigned in_q[$];
  bit           inv_q[$];
  byte unsigned acc[$];
  byte unsigned exp_q[$];
  byte unsigned obs_log[$];
  bit           last_log[$];
  int unsigned  fire_t[$];
  int unsigned  cyc = 0;
  int unsigned  gap_pct = 0;
  int unsigned  ordy_pct = 100;
  bit           hold_ready = 1'b0;

  blk_t V1_IN  = '{8'hd4,8'h27,8'h11,8'hae,8'he0,8'hbf,8'h98,8'hf1,8'hb8,8'hb4,8'h5d,8'he5,8'h1e,8'h41,8'h52,8'h30};
  blk_t V1_OUT = '{8'hd4,8'hbf,8'h5d,8'h30,8'he0,8'hb4,8'h52,8'hae,8'hb8,8'h41,8'h11,8'hf1,8'h1e,8'h27,8'h98,8'he5};
  blk_t V2_IN  = '{8'h49,8'hde,8'hd2,8'h89,8'h45,8'hdb,8'h96,8'hf1,8'h7f,8'h39,8'h87,8'h1a,8'h77,8'h02,8'h53,8'h3b};
  blk_t V2_OUT = '{8'h49,8'hdb,8'h87,8'h3b,8'h45,8'h39,8'h53,8'h89,8'h7f,8'h02,8'hd2,8'hf1,8'h77,8'hde,8'h96,8'h1a};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: view the block as a 4x4 grid and rotate row r by r places (left fwd, right inv).
  function automatic void ref_block(input blk_t blk, input bit inv, output blk_t res);
    byte unsigned st [4][4];
    byte unsigned tmp;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = blk[4*c+r];
    for (int r = 0; r < 4; r++) begin
      repeat (r) begin
        if (!inv) begin
          tmp = st[r][0]; st[r][0] = st[r][1]; st[r][1] = st[r][2]; st[r][2] = st[r][3]; st[r][3] = tmp;
        end else begin
          tmp = st[r][3]; st[r][3] = st[r][2]; st[r][2] = st[r][1]; st[r][1] = st[r][0]; st[r][0] = tmp;
        end
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[4*c+r] = st[r][c];
  endfunction

  task automatic add_block(input blk_t b, input bit inv);
    foreach (b[j]) in_q.push_back(b[j]);
    inv_q.push_back(inv);
  endtask

  task automatic clear_log();
    obs_log.delete(); last_log.delete(); fire_t.delete();
  endtask

  // One clock: drive at edge+1, check at edge+2, advance model on the edge.
  task automatic tick();
    bit   in_fire, out_fire;
    int   nb;
    blk_t blk, res;
    if (in_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
      in_valid = 1'b1;
      in_data  = in_q[0];
      in_inv   = (acc.size() == 0) ? inv_q[0] : 1'($urandom);
    end else begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_inv   = 1'($urandom);
    end
    out_ready = !hold_ready && ($urandom_range(99) < ordy_pct);
    #1;
    nb = (exp_q.size() + 15) / 16;
    chk("in_ready", in_ready, nb < 2);
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("out_data", out_data, exp_q[0]);
      chk("out_last", out_last, exp_q.size() % 16 == 1);
    end else begin
      chk("idle_data", out_data, 0);
      chk("idle_last", out_last, 0);
    end
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_fire) begin
      obs_log.push_back(out_data);
      last_log.push_back(out_last);
      fire_t.push_back(cyc);
    end
    @(posedge clock); #1;
    cyc++;
    if (out_fire && exp_q.size() > 0) void'(exp_q.pop_front());
    if (in_fire) begin
      acc.push_back(in_q.pop_front());
      if (acc.size() == 16) begin
        foreach (blk[j]) blk[j] = acc[j];
        ref_block(blk, inv_q.pop_front(), res);
        foreach (res[j]) exp_q.push_back(res[j]);
        acc.delete();
      end
    end
  endtask

  task automatic run_until_empty(input int maxc);
    int i = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && i < maxc) begin
      tick();
      i++;
    end
    chk("drain_bound", in_q.size() + exp_q.size(), 0);
  endtask

  task automatic cmp_log(input string tag, input blk_t e, input int offs);
    for (int j = 0; j < 16; j++)
      chk(tag, (offs + j < obs_log.size()) ? {24'h0, obs_log[offs+j]} : 32'hxxxxxxxx, e[j]);
  endtask

  initial begin : main
    blk_t rb, r4;
    int   i;
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; in_inv4 = 1'b0; out_ready4 = 1'b1;
    #12 resetn = 1'b1;
    @(posedge clock); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);

    // FIPS-197 round-1 vector followed back-to-back by a second block.
    clear_log();
    add_block(V1_IN, 1'b0);
    add_block(V2_IN, 1'b0);
    run_until_empty(200);
    cmp_log("fwd_blk1", V1_OUT, 0);
    cmp_log("fwd_blk2", V2_OUT, 16);
    chk("blk1_last", (last_log.size() >= 16) ? {31'h0, last_log[15]} : 32'hx, 1);
    chk("blk1_not_last", (last_log.size() >= 15) ? {31'h0, last_log[14]} : 32'hx, 0);
    chk("no_bubble", (fire_t.size() >= 17) ? fire_t[16] - fire_t[15] : 32'hx, 1);

    // Inverse mode restores the original state.
    clear_log();
    add_block(V1_OUT, 1'b1);
    run_until_empty(200);
    cmp_log("inv_blk", V1_IN, 0);

    // Backpressure: three blocks offered with the sink stalled.
    clear_log();
    hold_ready = 1'b1;
    add_block(V1_IN, 1'b0);
    add_block(V2_IN, 1'b0);
    add_block(V1_OUT, 1'b1);
    repeat (40) tick();
    chk("stall_in_ready", in_ready, 0);
    chk("stall_data", out_data, 8'hd4);
    hold_ready = 1'b0;
    run_until_empty(300);
    cmp_log("bp_blk1", V1_OUT, 0);
    cmp_log("bp_blk2", V2_OUT, 16);
    cmp_log("bp_blk3", V1_IN, 32);

    // Randomized traffic with input gaps, sink stalls and mixed modes.
    gap_pct = 30; ordy_pct = 60;
    for (int n = 0; n < 20; n++) begin
      foreach (rb[j]) rb[j] = 8'($urandom);
      add_block(rb, 1'($urandom));
    end
    run_until_empty(3000);
    gap_pct = 0; ordy_pct = 100;

    // Async reset with one block waiting and 7 beats of the next written.
    hold_ready = 1'b1;
    foreach (rb[j]) rb[j] = 8'($urandom);
    add_block(V2_IN, 1'b0);
    add_block(rb, 1'b0);
    i = 0;
    while (!(exp_q.size() == 16 && acc.size() == 7) && i < 100) begin
      tick();
      i++;
    end
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_last", out_last, 0);
    in_q.delete(); inv_q.delete(); acc.delete(); exp_q.delete();
    @(posedge clock); #3 resetn = 1'b1;
    @(posedge clock); #1;
    hold_ready = 1'b0;
    clear_log();
    add_block(V1_IN, 1'b0);
    run_until_empty(200);
    cmp_log("post_rst", V1_OUT, 0);
    chk("post_rst_count", obs_log.size(), 16);

    // Four lanes per beat.
    ref_block(V1_IN, 1'b0, r4);
    in_valid4 = 1'b1;
    for (int b = 0; b < 4; b++) begin
      in_data4 = {V1_IN[4*b+3], V1_IN[4*b+2], V1_IN[4*b+1], V1_IN[4*b]};
      in_inv4  = (b == 0) ? 1'b0 : 1'($urandom);
      #1;
      chk("l4_in_ready", in_ready4, 1);
      chk("l4_no_early_out", out_valid4, 0);
      @(posedge clock); #1;
    end
    in_valid4 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      if (b == 0) chk("l4_first_beat", out_data4, 32'h305dbfd4);
      chk("l4_valid", out_valid4, 1);
      chk("l4_data", out_data4, {r4[4*b+3], r4[4*b+2], r4[4*b+1], r4[4*b]});
      chk("l4_last", out_last4, b == 3);
      @(posedge clock); #1;
    end
    chk("l4_drained", out_valid4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
